// File: rtl/ir_nec_defs.sv
// Shared NEC timing definitions: FSM state encodings and segment lengths in
// NEC units. The receiver reuses the unit counts for its timing windows.
package ir_nec_defs;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LEAD_MARK  = 3'd1,
    LEAD_SPACE = 3'd2,
    BIT_MARK   = 3'd3,
    BIT_SPACE  = 3'd4,
    STOP_MARK  = 3'd5,
    GAP        = 3'd6
  } nec_state_t;

  localparam int unsigned LEAD_MARK_UNITS  = 16;
  localparam int unsigned LEAD_SPACE_UNITS = 8;
  localparam int unsigned BIT_MARK_UNITS   = 1;
  localparam int unsigned ZERO_SPACE_UNITS = 1;
  localparam int unsigned ONE_SPACE_UNITS  = 3;
  localparam int unsigned STOP_UNITS       = 1;

  // Segment duration counters count down to zero, so they load length-1.
  function automatic logic [4:0] dur_load(input int unsigned units);
    return 5'(units - 1);
  endfunction

endpackage

// File: rtl/ir_carrier_gen.sv
// Carrier divider for the IR LED. The output is already gated by the
// envelope: it is low whenever Env is low, and every mark starts with a
// full high half-period because the phase restarts on each Env rise.
// Env is expected one cycle early (the value the envelope register is about
// to take), so carrier lines up with the registered envelope.
module ir_carrier_gen #(
  parameter int unsigned CARRIER_HALF = 658
) (
  input  logic CLK,
  input  logic RST_n,
  input  logic Env,
  output logic carrier
);

  localparam int unsigned CW = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(CARRIER_HALF - 1);

  logic [CW-1:0] half_cnt_reg;
  logic          env_d_reg;

  // Phase-reset divider: restart high on Env rise, toggle every half period.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      half_cnt_reg <= '0;
      env_d_reg    <= 1'b0;
      carrier      <= 1'b0;
    end else begin
      env_d_reg <= Env;
      if (!Env) begin
        half_cnt_reg <= '0;
        carrier      <= 1'b0;
      end else if (!env_d_reg) begin
        half_cnt_reg <= '0;
        carrier      <= 1'b1;
      end else if (half_cnt_reg == HALF_LAST) begin
        half_cnt_reg <= '0;
        carrier      <= ~carrier;
      end else begin
        half_cnt_reg <= half_cnt_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ir_nec_tx.sv
// NEC infrared transmitter: leader, 32 data bits MSB first, stop mark and a
// gap that pads every frame to FRAME_UNITS units regardless of the code.
// UNIT_CYCLES must be at least 2 (Done is armed one cycle before the final
// unit tick).
module ir_nec_tx
  import ir_nec_defs::*;
#(
  parameter int unsigned UNIT_CYCLES  = 28125,
  parameter int unsigned CARRIER_HALF = 658,
  parameter bit          MODULATE     = 1'b1,
  parameter int unsigned FRAME_UNITS  = 192
) (
  input  logic        CLK,
  input  logic        RST_n,
  input  logic        Start,
  input  logic [31:0] Code,
  output logic        Busy,
  output logic        Done,
  output logic        Env,
  output logic        IR_Out
);

  localparam int unsigned UW = $clog2(UNIT_CYCLES);
  localparam int unsigned FW = $clog2(FRAME_UNITS + 1);
  localparam logic [UW-1:0] UNIT_LAST     = UW'(UNIT_CYCLES - 1);
  localparam logic [UW-1:0] UNIT_PRE_LAST = UW'(UNIT_CYCLES - 2);
  localparam logic [FW-1:0] FRAME_LAST    = FW'(FRAME_UNITS - 1);

  nec_state_t    state_reg;
  logic [UW-1:0] unit_cnt_reg;
  logic [FW-1:0] frame_cnt_reg;
  logic [4:0]    dur_cnt_reg;
  logic [5:0]    bit_cnt_reg;
  logic [31:0]   shift_reg;
  logic          busy_reg;
  logic          done_reg;
  logic          env_reg;

  logic unit_tick;
  logic seg_end;
  logic env_next;
  logic carrier;

  // Envelope lookahead: every segment boundary before the gap flips between
  // mark and space, so the next envelope is a toggle at each segment end.
  always_comb begin
    unit_tick = (state_reg != IDLE) && (unit_cnt_reg == UNIT_LAST);
    seg_end   = unit_tick && (dur_cnt_reg == '0) && (state_reg != GAP);
    env_next  = env_reg;
    if (state_reg == IDLE) begin
      env_next = Start;
    end else if (seg_end) begin
      env_next = ~env_reg;
    end
  end

  // Frame sequencer: unit timing, segment durations, bit shifting, outputs.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_reg     <= IDLE;
      unit_cnt_reg  <= '0;
      frame_cnt_reg <= '0;
      dur_cnt_reg   <= '0;
      bit_cnt_reg   <= '0;
      shift_reg     <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      env_reg       <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      env_reg  <= env_next;
      case (state_reg)
        IDLE: begin
          if (Start) begin
            shift_reg     <= Code;
            unit_cnt_reg  <= '0;
            frame_cnt_reg <= '0;
            bit_cnt_reg   <= '0;
            dur_cnt_reg   <= dur_load(LEAD_MARK_UNITS);
            busy_reg      <= 1'b1;
            state_reg     <= LEAD_MARK;
          end
        end
        default: begin
          unit_cnt_reg <= unit_tick ? '0 : unit_cnt_reg + 1'b1;
          if (unit_tick) begin
            frame_cnt_reg <= frame_cnt_reg + 1'b1;
            if (dur_cnt_reg != '0) begin
              dur_cnt_reg <= dur_cnt_reg - 1'b1;
            end else begin
              case (state_reg)
                LEAD_MARK: begin
                  state_reg   <= LEAD_SPACE;
                  dur_cnt_reg <= dur_load(LEAD_SPACE_UNITS);
                end
                LEAD_SPACE: begin
                  state_reg   <= BIT_MARK;
                  dur_cnt_reg <= dur_load(BIT_MARK_UNITS);
                end
                BIT_MARK: begin
                  state_reg   <= BIT_SPACE;
                  dur_cnt_reg <= shift_reg[31] ? dur_load(ONE_SPACE_UNITS)
                                               : dur_load(ZERO_SPACE_UNITS);
                end
                BIT_SPACE: begin
                  shift_reg <= {shift_reg[30:0], 1'b0};
                  if (bit_cnt_reg == 6'd31) begin
                    bit_cnt_reg <= '0;
                    state_reg   <= STOP_MARK;
                    dur_cnt_reg <= dur_load(STOP_UNITS);
                  end else begin
                    bit_cnt_reg <= bit_cnt_reg + 1'b1;
                    state_reg   <= BIT_MARK;
                    dur_cnt_reg <= dur_load(BIT_MARK_UNITS);
                  end
                end
                STOP_MARK: begin
                  state_reg   <= GAP;
                  dur_cnt_reg <= '0;
                end
                default: ;
              endcase
            end
          end
          // The gap ends on the frame counter, not on a segment length.
          if ((state_reg == GAP) && (frame_cnt_reg == FRAME_LAST)) begin
            if (unit_cnt_reg == UNIT_PRE_LAST) begin
              done_reg <= 1'b1;
            end
            if (unit_tick) begin
              state_reg     <= IDLE;
              busy_reg      <= 1'b0;
              unit_cnt_reg  <= '0;
              frame_cnt_reg <= '0;
            end
          end
        end
      endcase
    end
  end

  ir_carrier_gen #(
    .CARRIER_HALF(CARRIER_HALF)
  ) u_carrier (
    .CLK    (CLK),
    .RST_n  (RST_n),
    .Env    (env_next),
    .carrier(carrier)
  );

  generate
    if (MODULATE) begin : g_mod
      assign IR_Out = carrier;
    end else begin : g_nomod
      assign IR_Out = env_reg;
    end
  endgenerate

  assign Busy = busy_reg;
  assign Done = done_reg;
  assign Env  = env_reg;

endmodule

// File: tb/tb_ir_nec_tx.sv
// Bench for ir_nec_tx with short units. A frame-level model predicts Env,
// IR_Out, Busy and Done for every cycle; a space-width decoder recovers the
// transmitted word and pins the model with hand-computed frame figures.
module tb_ir_nec_tx;

  localparam int U  = 4;
  localparam int H  = 1;
  localparam int F  = 192;
  localparam int FRAME_CYC = F * U;

  logic        CLK   = 1'b0;
  logic        RST_n = 1'b0;
  logic        Start = 1'b0;
  logic [31:0] Code  = '0;
  logic        Busy, Done, Env, IR_Out;

  int vecs = 0;
  int errs = 0;
  int fail_prints = 0;

  ir_nec_tx #(
    .UNIT_CYCLES (U),
    .CARRIER_HALF(H),
    .MODULATE    (1'b1),
    .FRAME_UNITS (F)
  ) dut (
    .CLK   (CLK),
    .RST_n (RST_n),
    .Start (Start),
    .Code  (Code),
    .Busy  (Busy),
    .Done  (Done),
    .Env   (Env),
    .IR_Out(IR_Out)
  );

  initial forever #5 CLK = ~CLK;

  // Envelope at cycle idx after acceptance, walking the NEC segment list.
  function automatic bit exp_env(input logic [31:0] code, input int idx);
    int u;
    u = idx / U;
    if (u < 16) return 1'b1;
    u -= 16;
    if (u < 8) return 1'b0;
    u -= 8;
    for (int b = 31; b >= 0; b--) begin
      int sp;
      sp = code[b] ? 3 : 1;
      if (u == 0) return 1'b1;
      if (u <= sp) return 1'b0;
      u -= 1 + sp;
    end
    return (u == 0);
  endfunction

  // LED drive: carrier phase counted from the start of the current mark.
  function automatic bit exp_ir(input logic [31:0] code, input int idx);
    int j;
    if (!exp_env(code, idx)) return 1'b0;
    j = 0;
    while (j < idx && exp_env(code, idx - j - 1)) j++;
    return ((j / H) % 2) == 0;
  endfunction

  // Frame model state: active frame, cycle index within it, latched code.
  logic        m_active = 1'b0;
  int          m_idx    = 0;
  logic [31:0] m_code   = '0;

  initial forever begin
    @(posedge CLK or negedge RST_n);
    if (!RST_n) begin
      m_active = 1'b0;
    end else if (m_active) begin
      if (m_idx == FRAME_CYC - 1) m_active = 1'b0;
      else m_idx++;
    end else if (Start) begin
      m_active = 1'b1;
      m_idx    = 0;
      m_code   = Code;
    end
  end

  task automatic report(input string name, input int act, input int req);
    errs++;
    if (fail_prints < 40) begin
      fail_prints++;
      $display("FAIL %s at %0t: actual %0d required %0d", name, $time, act, req);
    end
  endtask

  // Cycle compare against the model, sampled on the falling edge.
  initial begin : cmp
    bit e_env, e_ir, e_busy, e_done;
    forever begin
      @(negedge CLK);
      e_env  = m_active ? exp_env(m_code, m_idx) : 1'b0;
      e_ir   = m_active ? exp_ir(m_code, m_idx) : 1'b0;
      e_busy = m_active;
      e_done = m_active && (m_idx == FRAME_CYC - 1);
      vecs++;
      if (Env    !== e_env ) report("env",    int'(Env),    int'(e_env));
      if (IR_Out !== e_ir  ) report("ir_out", int'(IR_Out), int'(e_ir));
      if (Busy   !== e_busy) report("busy",   int'(Busy),   int'(e_busy));
      if (Done   !== e_done) report("done",   int'(Done),   int'(e_done));
    end
  end

  // Space-width decoder and per-frame statistics.
  int          gcyc = 0, cyc = 0, busy_cnt = 0, done_cnt = 0, done_at = 0;
  int          lead_len = 0, marks = 0, sp = 0, run = 0, last_high = 0;
  int          nbits = 0, bad = 0, prev_rise = 0, last_rise = 0;
  logic [31:0] word = '0;
  logic        busy_d = 1'b0, env_d = 1'b0;

  initial forever begin
    @(negedge CLK);
    gcyc++;
    if (Busy && !busy_d) begin
      prev_rise = last_rise; last_rise = gcyc;
      cyc = 0; busy_cnt = 0; done_cnt = 0; done_at = 0; lead_len = 0;
      marks = 0; sp = 0; run = 0; last_high = 0; nbits = 0; bad = 0; word = '0;
    end
    if (Busy) begin
      cyc++;
      busy_cnt++;
      if (Done) begin done_cnt++; done_at = cyc; end
      if (Env) begin
        if (!env_d) begin
          if (marks > 0) begin
            if (sp == 4) begin word = {word[30:0], 1'b0}; nbits++; end
            else if (sp == 12) begin word = {word[30:0], 1'b1}; nbits++; end
            else if (!(marks == 1 && sp == 32)) bad++;
          end
          run = 0;
        end
        run++;
        last_high = cyc;
      end else begin
        if (env_d) begin
          if (marks == 0) lead_len = run;
          marks++;
          sp = 0;
        end
        sp++;
      end
    end
    busy_d = Busy;
    env_d  = Env;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vecs++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic send(input logic [31:0] code);
    @(posedge CLK); #1;
    Code  = code;
    Start = 1'b1;
    @(posedge CLK); #1;
    Start = 1'b0;
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge CLK);
      if (Done) seen = 1'b1;
    end
    vecs++;
    if (!seen) begin
      errs++;
      $display("FAIL done_timeout: actual none required pulse within 2000 cycles");
    end
    repeat (3) @(negedge CLK);
  endtask

  task automatic wait_cyc(input int target);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 2000 && !hit; i++) begin
      @(posedge CLK);
      if (Busy && cyc >= target) hit = 1'b1;
    end
    vecs++;
    if (!hit) begin
      errs++;
      $display("FAIL cyc_timeout: actual %0d required %0d", cyc, target);
    end
  endtask

  task automatic check_frame(input logic [31:0] code, input int exp_last_high);
    $display("frame code=%h decoded=%h bits=%0d busy=%0d done_at=%0d last_mark=%0d",
             code, word, nbits, busy_cnt, done_at, last_high);
    chk("lead_mark_len", lead_len,  64);
    chk("busy_len",      busy_cnt,  768);
    chk("done_count",    done_cnt,  1);
    chk("done_at",       done_at,   768);
    chk("bit_count",     nbits,     32);
    chk("bad_space",     bad,       0);
    chk("last_mark",     last_high, exp_last_high);
    chk("decoded_word",  word,      code);
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    chk("reset_busy", Busy,   0);
    chk("reset_env",  Env,    0);
    chk("reset_ir",   IR_Out, 0);
    RST_n = 1'b1;

    send(32'h00000000); wait_done(); check_frame(32'h00000000, 356);
    send(32'hFFFFFFFF); wait_done(); check_frame(32'hFFFFFFFF, 612);
    send(32'h1BE4FD02); wait_done(); check_frame(32'h1BE4FD02, 484);
    send(32'h8E7112ED); wait_done(); check_frame(32'h8E7112ED, 484);
    chk("upper_half", {16'h0, word[31:16]}, 32'h00008E71);

    // Start and Code changes mid-frame must not disturb the latched word.
    send(32'h36C9A55A);
    wait_cyc(200);
    #1;
    Code  = 32'hFFFF0000;
    Start = 1'b1;
    @(posedge CLK); #1;
    Start = 1'b0;
    Code  = 32'h0;
    wait_done(); check_frame(32'h36C9A55A, 484);

    // Start held high across Done: next acceptance one cycle after the frame.
    @(posedge CLK); #1;
    Code  = 32'h00000000;
    Start = 1'b1;
    wait_done();
    for (int i = 0; i < 20 && !Busy; i++) @(posedge CLK);
    #1;
    Start = 1'b0;
    wait_done();
    chk("b2b_spacing", last_rise - prev_rise, 769);
    check_frame(32'h00000000, 356);

    // Asynchronous reset in the middle of a mark.
    send(32'h16E900FF);
    wait_cyc(299);
    @(negedge CLK);
    chk("pre_reset_env", Env, 1);
    #2;
    RST_n = 1'b0;
    #1;
    chk("async_env",  Env,    0);
    chk("async_ir",   IR_Out, 0);
    chk("async_busy", Busy,   0);
    @(posedge CLK);
    @(negedge CLK);
    RST_n = 1'b1;
    repeat (5) @(negedge CLK);
    chk("no_resume_busy", Busy, 0);
    send(32'h16E900FF); wait_done(); check_frame(32'h16E900FF, 484);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/ir_nec_tx.md
Name: ir_nec_tx

Overview:
- NEC-format infrared transmitter; the sending end of the 32-bit IR link whose decoded word drives the calculator's button emulation.
- Takes a 32-bit code on a start strobe and emits the leader, 32 data bits, stop mark and inter-frame gap on an IR LED output.
- Used on remote/test boards to drive the receiver, e.g. 32'h1BE4FD02 for power, or codes with upper half 16'h8E71/16'h36C9/16'h16E9 for sum/sub/mult.

Parameters:
- UNIT_CYCLES, 28125, clock cycles per 562.5 us NEC unit (50 MHz clock)
- CARRIER_HALF, 658, clock cycles per half-period of the ~38 kHz carrier
- MODULATE, 1, 1: IR_Out = envelope AND carrier; 0: IR_Out = envelope
- FRAME_UNITS, 192, frame period in units (108 ms), measured from start of leader to end of gap

Ports:
- CLK  in  1  system clock
- RST_n  in  1  asynchronous active-low reset
- Start  in  1  request to send; sampled only in IDLE
- Code  in  32  word to send; Code[31] transmitted first
- Busy  out  1  high from the cycle after Start is accepted until the end of the gap
- Done  out  1  one-cycle pulse in the last GAP cycle
- Env  out  1  unmodulated envelope (1 = mark)
- IR_Out  out  1  LED drive

Behaviour:
- Reset (async, RST_n low): state IDLE; Busy=0, Done=0, Env=0, IR_Out=0; all counters and the shift register cleared. Releasing reset mid-frame never resumes the frame.
- Unit tick: a counter runs 0..UNIT_CYCLES-1 and ticks on wrap. It is cleared on Start acceptance, so every unit is exactly UNIT_CYCLES cycles.
- Accept: in IDLE with Start=1 at edge k, Code is latched into a shift register. From cycle k+1: state LEAD_MARK, Busy=1, Env=1.
- States and durations (units): LEAD_MARK 16 -> LEAD_SPACE 8 -> BIT_MARK 1 -> BIT_SPACE (1 if current bit 0, 3 if 1) -> back to BIT_MARK until 32 bits are sent -> STOP_MARK 1 -> GAP.
- Env is 1 in LEAD_MARK, BIT_MARK and STOP_MARK, and 0 elsewhere.
- Shift register shifts left at the end of each BIT_SPACE. A 6-bit bit counter counts 0..31.
- A frame-unit counter counts every unit from acceptance. GAP lasts until this counter reaches FRAME_UNITS, so a frame occupies exactly 192 units whatever the code. Data length is 89 units for all zeros and 153 units for all ones; minimum gap is 39 units.
- Done=1 in the last cycle of GAP. State IDLE and Busy=0 follow on the next cycle.
- Back-to-back: Start held high through Done is accepted in the IDLE cycle after Done, so frames are spaced by FRAME_UNITS*UNIT_CYCLES+1 cycles.
- Start or Code changes while Busy are ignored; the latched word is used.
- Carrier: a counter toggles the carrier every CARRIER_HALF cycles. It is reset to phase 0 (carrier high) on every Env 0->1 edge so each mark starts with a high pulse. The carrier is held low while Env=0.
- IR_Out is registered; it lags Env by 0 cycles (same register stage as Env).

Decomposition:
- Shared constants header/package ir_nec_defs: state encodings (IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK, GAP) and unit counts (LEAD_MARK_UNITS=16, LEAD_SPACE_UNITS=8, BIT_MARK_UNITS=1, ZERO_SPACE_UNITS=1, ONE_SPACE_UNITS=3, STOP_UNITS=1). The receiver reuses these for its timing windows.
- One sub-module, ir_carrier_gen (CLK, RST_n, Env -> carrier), containing the phase-reset divider. The FSM and counters stay in ir_nec_tx.

Test Plan (UNIT_CYCLES=4, CARRIER_HALF=1, FRAME_UNITS=192):
- Code=32'h00000000, Start pulse -> Env high 64 cycles, low 32, then 32x(4 high, 4 low), then 4 high. Busy high 768 cycles; Done pulses once at cycle 768 after acceptance.
- Code=32'hFFFFFFFF -> each bit space is 12 cycles; last Env fall at 612 cycles; Busy still exactly 768 cycles.
- Code=32'h1BE4FD02 -> bench decoder measuring space widths (4 = 0, 12 = 1, MSB first) recovers 32'h1BE4FD02. Repeat with 32'h8E71xxxx -> upper half 16'h8E71.
- Start re-pulsed with Code=32'hFFFF0000 at cycle 200 of a frame -> ignored; decoded word equals the originally latched code; exactly one Done.
- RST_n low for 1 cycle at cycle 300 -> Env, IR_Out, Busy = 0 immediately (async); IDLE; new Start accepted normally.
- MODULATE=1 -> during a mark IR_Out toggles every cycle, first cycle high; IR_Out=0 throughout every space and the gap.
